// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared types and constants for the 4x4 matrix keypad scanner.
//   kp_state_t    : debounce FSM states
//   key_code_t    : key index, row*4+col
//   ROW_ONEHOT_N  : active-low row drive pattern, one entry per row
//   lowest_idx()  : index of the lowest set bit of a 16-bit key snapshot
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} kp_state_t;

    typedef logic [3:0] key_code_t;

    localparam logic [3:0] ROW_ONEHOT_N [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic key_code_t lowest_idx(input logic [15:0] v);
        lowest_idx = '0;
        // Walk downwards so the last hit (lowest index) wins.
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_idx = key_code_t'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_scan_sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a bus of independent async bits.
//   clk     : destination clock
//   resetn  : synchronous active-low reset; flops reset to all-ones
//             (idle level of pulled-up, active-low keypad columns)
//   d_i     : asynchronous input
//   q_o     : synchronized output, 2 clk latency
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 active-low matrix keypad scanner with frame-based
// debounce and a one-entry valid/ready event register.
//   clk, resetn  : clock, synchronous active-low reset
//   busin_col    : keypad columns, active-low, asynchronous
//   busout_row   : one-hot-low row drive
//   key_code     : key index of pending event
//   key_release  : 1 = release event, 0 = press event
//   key_valid    : event pending; cleared by key_valid && key_ready
//   key_ready    : consumer ready
//   key_pressed  : debounced key currently held
//   overflow     : sticky, an event was dropped
// Build option: define KEYPAD_RELEASE_EN to emit release events; otherwise
// key_release is tied low and only press events are delivered.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W     = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] busin_col,
    output logic [3:0] busout_row,
    output logic [3:0] key_code,
    output logic       key_release,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_pressed,
    output logic       overflow
);

    localparam int               CNT_W      = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [SCAN_DIV_W-1:0] presc_q;
    logic [1:0]            row_q;
    logic [3:0]            col_s;
    logic [15:0]           snap_q, snap_d, prev_q;
    logic [CNT_W-1:0]      stable_q, stable_d, rel_cnt_q;
    kp_state_t             state_q;
    key_code_t             latch_q, out_code_q;
    logic                  valid_q, pressed_q, ovf_q, wait_clr_q;
    logic                  slot_end, frame_end, press_hit, rel_hit, ev_fire;
    key_code_t             ev_code;

    sync_2ff #(.W(4)) u_col_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (busin_col),
        .q_o    (col_s)
    );

    assign slot_end  = &presc_q;
    assign frame_end = slot_end && (row_q == 2'd3);

    // Snapshot including the row being sampled this cycle; at frame end this
    // is the completed frame.
    always_comb begin
        snap_d = snap_q;
        snap_d[{row_q, 2'b00} +: 4] = ~col_s;
        stable_d = '0;
        if (snap_d == prev_q)
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + CNT_W'(1);
    end

    assign press_hit = frame_end && (state_q == PRESS_CHK) && (snap_d != '0) &&
                       (stable_d == STABLE_MAX);
    assign rel_hit   = frame_end && (state_q == REL_CHK) && !snap_d[latch_q] &&
                       (rel_cnt_q == STABLE_MAX);
`ifdef KEYPAD_RELEASE_EN
    assign ev_fire = press_hit || rel_hit;
`else
    assign ev_fire = press_hit;
`endif
    assign ev_code = press_hit ? lowest_idx(snap_d) : latch_q;

    // Scan timing and snapshot capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q  <= '0;
            row_q    <= '0;
            snap_q   <= '0;
            prev_q   <= '0;
            stable_q <= '0;
        end else begin
            presc_q <= presc_q + SCAN_DIV_W'(1);
            if (slot_end) begin
                row_q  <= row_q + 2'd1;
                snap_q <= snap_d;
            end
            if (frame_end) begin
                prev_q   <= snap_d;
                stable_q <= stable_d;
            end
        end
    end

`ifdef KEYPAD_RELEASE_EN
    logic rel_out_q;
`endif

    // Debounce FSM and event holding register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            latch_q    <= '0;
            rel_cnt_q  <= '0;
            pressed_q  <= 1'b0;
            wait_clr_q <= 1'b0;
            valid_q    <= 1'b0;
            out_code_q <= '0;
            ovf_q      <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
            rel_out_q  <= 1'b0;
`endif
        end else begin
            if (frame_end) begin
                // After a release, keys still held must all lift before a new
                // press can be qualified; otherwise a second held key would
                // immediately report as a fresh press.
                if (snap_d == '0) wait_clr_q <= 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (snap_d != '0 && !wait_clr_q) state_q <= PRESS_CHK;
                    end
                    PRESS_CHK: begin
                        if (snap_d == '0) begin
                            state_q <= IDLE;
                        end else if (press_hit) begin
                            latch_q   <= ev_code;
                            pressed_q <= 1'b1;
                            state_q   <= HELD;
                        end
                    end
                    HELD: begin
                        if (!snap_d[latch_q]) begin
                            rel_cnt_q <= CNT_W'(1);
                            state_q   <= REL_CHK;
                        end
                    end
                    REL_CHK: begin
                        if (snap_d[latch_q]) begin
                            state_q <= HELD;
                        end else if (rel_hit) begin
                            pressed_q  <= 1'b0;
                            wait_clr_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            rel_cnt_q <= rel_cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (ev_fire) begin
                if (valid_q && !key_ready) begin
                    ovf_q <= 1'b1;
                end else begin
                    valid_q    <= 1'b1;
                    out_code_q <= ev_code;
`ifdef KEYPAD_RELEASE_EN
                    rel_out_q  <= rel_hit;
`endif
                end
            end else if (valid_q && key_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign busout_row  = ROW_ONEHOT_N[row_q];
    assign key_code    = out_code_q;
    assign key_valid   = valid_q;
    assign key_pressed = pressed_q;
    assign overflow    = ovf_q;
`ifdef KEYPAD_RELEASE_EN
    assign key_release = rel_out_q;
`else
    assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan -- scoreboard bench for keypad_scan (4-clk slot, 16-clk
// frame, 3-frame debounce). A keypad model drives the columns from the row
// drive; expected events are queued as keys are changed and a monitor pops
// and compares on each handshake. Release events are expected only when
// KEYPAD_RELEASE_EN is defined.
module tb_keypad_scan;

    localparam int FR = 16;

    typedef struct packed {
        logic [3:0] code;
        logic       rel;
    } ev_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  busin_col;
    logic [3:0]  busout_row;
    logic [3:0]  key_code;
    logic        key_release;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic        key_pressed;
    logic        overflow;
    logic [15:0] keys = '0;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    ev_t         exp_q[$];
    logic [3:0]  rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_DIV_W(2), .DEBOUNCE_SCANS(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .busin_col   (busin_col),
        .busout_row  (busout_row),
        .key_code    (key_code),
        .key_release (key_release),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_pressed (key_pressed),
        .overflow    (overflow)
    );

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        case (busout_row)
            4'b1110: busin_col = ~keys[3:0];
            4'b1101: busin_col = ~keys[7:4];
            4'b1011: busin_col = ~keys[11:8];
            4'b0111: busin_col = ~keys[15:12];
            default: busin_col = 4'hF;
        endcase
    end

    // Cycles since reset release; equals the prescaler/row position.
    always @(posedge clk) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] code, input logic rel);
        ev_t e;
        e.code = code;
        e.rel  = rel;
        exp_q.push_back(e);
    endtask

    task automatic frames(input int n);
        repeat (n * FR) @(negedge clk);
    endtask

    // Advance to the negedge of the first cycle of a scan frame.
    task automatic fstart();
        do @(negedge clk); while (cyc % FR != 0);
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (resetn && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event got code %0d rel %0d expected none at %0t",
                         key_code, key_release, $time);
            end else begin
                e = exp_q.pop_front();
                chk("ev_code", 16'(key_code), 16'(e.code));
                chk("ev_rel", 16'(key_release), 16'(e.rel));
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_row", 16'(busout_row), 16'h000E);
        chk("rst_valid", 16'(key_valid), 16'h0);
        chk("rst_code", 16'(key_code), 16'h0);
        chk("rst_rel", 16'(key_release), 16'h0);
        chk("rst_pressed", 16'(key_pressed), 16'h0);
        chk("rst_ovf", 16'(overflow), 16'h0);
        resetn = 1'b1;

        // 1. Row scan sequence
        chk("scan_row0", 16'(busout_row), 16'(rows[0]));
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("scan_row", 16'(busout_row), 16'(rows[(k / 4) % 4]));
            chk("scan_valid", 16'(key_valid), 16'h0);
        end

        // 2. Press key 6; event loads one clk after the third frame end
        fstart();
        keys[6] = 1'b1;
        push(4'd6, 1'b0);
        repeat (47) @(negedge clk);
        chk("t2_pre_valid", 16'(key_valid), 16'h0);
        @(negedge clk);
        chk("t2_valid", 16'(key_valid), 16'h1);
        chk("t2_code", 16'(key_code), 16'h6);
        @(negedge clk);
        chk("t2_pulse", 16'(key_valid), 16'h0);
        frames(2);
        chk("t2_pressed", 16'(key_pressed), 16'h1);
        chk("t2_drain", 16'(exp_q.size()), 16'h0);

        // Release key 6
        keys[6] = 1'b0;
`ifdef KEYPAD_RELEASE_EN
        push(4'd6, 1'b1);
`endif
        frames(5);
        chk("t6_rel_pressed", 16'(key_pressed), 16'h0);
        chk("t6_rel_drain", 16'(exp_q.size()), 16'h0);

        // 3. Bouncing key 6: toggled each frame, never qualifies
        fstart();
        for (int f = 0; f < 10; f++) begin
            keys[6] = ~keys[6];
            frames(1);
        end
        keys[6] = 1'b0;
        frames(4);
        chk("t3_pressed", 16'(key_pressed), 16'h0);
        chk("t3_drain", 16'(exp_q.size()), 16'h0);

        // 4. Keys 9 and 2 together -> lowest index 2
        fstart();
        keys[9] = 1'b1;
        keys[2] = 1'b1;
        push(4'd2, 1'b0);
        frames(5);
        chk("t4_pressed", 16'(key_pressed), 16'h1);
        chk("t4_drain", 16'(exp_q.size()), 16'h0);
        keys[2] = 1'b0;
`ifdef KEYPAD_RELEASE_EN
        push(4'd2, 1'b1);
`endif
        frames(8);
        chk("t4_rel2_pressed", 16'(key_pressed), 16'h0);
        chk("t4_rel2_drain", 16'(exp_q.size()), 16'h0);
        keys[9] = 1'b0;
        frames(3);
        fstart();
        keys[9] = 1'b1;
        push(4'd9, 1'b0);
        frames(5);
        chk("t4_p9_pressed", 16'(key_pressed), 16'h1);
        chk("t4_p9_drain", 16'(exp_q.size()), 16'h0);
        keys[9] = 1'b0;
`ifdef KEYPAD_RELEASE_EN
        push(4'd9, 1'b1);
`endif
        frames(5);
        chk("t4_rel9_pressed", 16'(key_pressed), 16'h0);

        // 5. Overflow with key_ready low
        key_ready = 1'b0;
        fstart();
        keys[6] = 1'b1;
        push(4'd6, 1'b0);
        frames(5);
        keys[6] = 1'b0;
        frames(5);
        fstart();
        keys[3] = 1'b1;
        frames(5);
        chk("t5_valid", 16'(key_valid), 16'h1);
        chk("t5_code", 16'(key_code), 16'h6);
        chk("t5_ovf", 16'(overflow), 16'h1);
        keys[3] = 1'b0;
        frames(6);
        // Next press qualifies at the end of its third frame; accept the held
        // event in that same cycle.
        fstart();
        keys[5] = 1'b1;
        push(4'd5, 1'b0);
        repeat (46) @(negedge clk);
        @(posedge clk);
        #1 key_ready = 1'b1;
        frames(2);
        chk("t5_ovf_kept", 16'(overflow), 16'h1);
        chk("t5_valid_clr", 16'(key_valid), 16'h0);
        chk("t5_pressed", 16'(key_pressed), 16'h1);
        chk("t5_drain", 16'(exp_q.size()), 16'h0);
        keys[5] = 1'b0;
`ifdef KEYPAD_RELEASE_EN
        push(4'd5, 1'b1);
`endif
        frames(5);
        chk("t5_rel_pressed", 16'(key_pressed), 16'h0);

        // 6. Reset during PRESS_CHK
        fstart();
        keys[6] = 1'b1;
        frames(1);
        repeat (8) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_row", 16'(busout_row), 16'h000E);
        chk("mr_valid", 16'(key_valid), 16'h0);
        chk("mr_code", 16'(key_code), 16'h0);
        chk("mr_pressed", 16'(key_pressed), 16'h0);
        chk("mr_ovf", 16'(overflow), 16'h0);
        keys[6] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        frames(5);
        chk("mr_post_pressed", 16'(key_pressed), 16'h0);
        chk("mr_post_valid", 16'(key_valid), 16'h0);
        chk("final_drain", 16'(exp_q.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
